// File: rtl/mem_stage_sram_controller.sv
// MEM stage SRAM sequencer: 32-bit loads/stores/push/pop
// on a 16-bit SRAM in two wait-stated half-word phases.
module mem_stage_sram_controller #(
  parameter int          ADDR_W      = 18,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter logic [31:0] STACK_TOP   = 32'h0000_0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              pushEn,
  input  logic              popEn,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       reg2Val,
  output logic [31:0]       readData,
  output logic              ready,
  output logic [31:0]       sp,
  output logic [ADDR_W-1:0] sramAddr,
  output logic [15:0]       sramDQOut,
  output logic              sramDQOutEn,
  input  logic [15:0]       sramDQIn,
  output logic              sramWE_N
);

  localparam int CW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              is_wr;
  logic              is_pop;
  logic [ADDR_W-2:0] w_q;
  logic [31:0]       data_q;

  logic              req;
  logic              req_wr;
  logic [31:0]       sp_dec;
  logic [31:0]       req_addr;
  logic [31:0]       off;
  logic [ADDR_W-2:0] w_addr;
  logic              unused_off;

  assign req    = pushEn | popEn | memWrite | memRead;
  assign req_wr = pushEn | (~popEn & memWrite);
  assign sp_dec = sp - 32'd4;
  assign off    = req_addr - BASE_ADDR;
  assign w_addr = off[ADDR_W:2];
  assign unused_off = ^{off[31:ADDR_W+1], off[1:0]};

  assign ready = (state == IDLE && !req) || (state == DONE);

  // Byte address of the granted request (push > pop > load/store)
  always_comb begin
    req_addr = ALUResult;
    if (pushEn)
      req_addr = sp_dec;
    else if (popEn)
      req_addr = sp;
  end

  // Access sequencer with registered SRAM pins and stack pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_wr       <= 1'b0;
      is_pop      <= 1'b0;
      w_q         <= '0;
      data_q      <= '0;
      sp          <= STACK_TOP;
      readData    <= '0;
      sramAddr    <= '0;
      sramDQOut   <= '0;
      sramDQOutEn <= 1'b0;
      sramWE_N    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            is_wr    <= req_wr;
            is_pop   <= ~pushEn & popEn;
            w_q      <= w_addr;
            data_q   <= reg2Val;
            cnt      <= CNT_INIT;
            sramAddr <= {w_addr, 1'b0};
            if (req_wr)
              sramDQOut <= reg2Val[15:0];
            sramWE_N    <= ~req_wr;
            sramDQOutEn <= req_wr;
            if (pushEn)
              sp <= sp_dec;
            state <= LO;
          end
        end
        LO: begin
          if (cnt == '0) begin
            if (!is_wr)
              readData[15:0] <= sramDQIn;
            else
              sramDQOut <= data_q[31:16];
            sramAddr <= {w_q, 1'b1};
            cnt      <= CNT_INIT;
            state    <= HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HI: begin
          if (cnt == '0) begin
            if (!is_wr)
              readData[31:16] <= sramDQIn;
            if (is_pop)
              sp <= sp + 32'd4;
            sramWE_N    <= 1'b1;
            sramDQOutEn <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
